// File: rtl/div_ctrl_pkg.sv
// Shared constants for the multi-cycle divider: FSM encodings and the
// ready/start handshake levels used by div_ctrl and its step datapath.
package div_ctrl_pkg;

   localparam int DIV_DATA_W = 32;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on the packed {rem, quot} working register.
module div_step
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic [2*DATA_W-1:0] rq_i,
   input  logic [DATA_W-1:0]   divisor_i,
   output logic [2*DATA_W-1:0] rq_o
);

   // Shifted partial remainder keeps the bit pushed out of rem's MSB, so
   // divisors with the top bit set still compare correctly.
   logic [DATA_W:0]   part;
   logic [DATA_W+1:0] diff;
   logic              borrow;

   assign part   = rq_i[2*DATA_W-1:DATA_W-1];
   assign diff   = {1'b0, part} - {2'b00, divisor_i};
   assign borrow = diff[DATA_W+1];

   assign rq_o[DATA_W-1:0]        = {rq_i[DATA_W-2:0], ~borrow};
   assign rq_o[2*DATA_W-1:DATA_W] = borrow ? part[DATA_W-1:0] : diff[DATA_W-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Division sequencer for DIV/DIVU: holds the pipeline while the restoring
// datapath iterates, then presents {remainder, quotient} until EX drops start.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                stallreq_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   div_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*DATA_W-1:0] rq_q, rq_d, rq_step;
   logic [DATA_W-1:0]   dvs_q, dvs_d;
   logic                negq_q, negq_d, negr_q, negr_d;
   logic [2*DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0]   abs1, abs2, quot_fix, rem_fix;

   assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? ({DATA_W{1'b0}} - opdata1_i) : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? ({DATA_W{1'b0}} - opdata2_i) : opdata2_i;

   assign quot_fix = negq_q ? ({DATA_W{1'b0}} - rq_q[DATA_W-1:0]) : rq_q[DATA_W-1:0];
   assign rem_fix  = negr_q ? ({DATA_W{1'b0}} - rq_q[2*DATA_W-1:DATA_W])
                            : rq_q[2*DATA_W-1:DATA_W];

   div_step #(.DATA_W(DATA_W)) u_step (
      .rq_i      (rq_q),
      .divisor_i (dvs_q),
      .rq_o      (rq_step)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= DivFree;
         cnt_q    <= '0;
         rq_q     <= '0;
         dvs_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rq_q     <= rq_d;
         dvs_q    <= dvs_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rq_d       = rq_q;
      dvs_d      = dvs_q;
      negq_d     = negq_q;
      negr_d     = negr_q;
      result_d   = result_q;
      stallreq_o = DivStop;
      case (state_q)
         DivFree: begin
            result_d = '0;
            // Annul beats start: a flushed instruction must not launch a divide.
            if (start_i == DivStart && !annul_i) begin
               stallreq_o = DivStart;
               if (opdata2_i == '0) begin
                  state_d = DivByZero;
               end else begin
                  state_d = DivOn;
                  cnt_d   = '0;
                  rq_d    = {{DATA_W{1'b0}}, abs1};
                  dvs_d   = abs2;
                  negq_d  = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                  negr_d  = signed_div_i && opdata1_i[DATA_W-1];
               end
            end
         end
         DivByZero: begin
            stallreq_o = DivStart;
            result_d   = '0;
            state_d    = DivEnd;
         end
         DivOn: begin
            stallreq_o = DivStart;
            if (annul_i) begin
               state_d  = DivFree;
               result_d = '0;
            end else if (cnt_q != CNT_W'(DATA_W)) begin
               rq_d  = rq_step;
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               result_d = {rem_fix, quot_fix};
               state_d  = DivEnd;
            end
         end
         DivEnd: begin
            if (start_i == DivStop) begin
               state_d  = DivFree;
               result_d = '0;
            end
         end
         default: state_d = DivFree;
      endcase
   end

   assign result_o = result_q;
   assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases from the divider's corner
// behaviour plus randomized divides against a plain-arithmetic reference.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, annul, sgn;
   logic [31:0] op1, op2;
   logic [63:0] result;
   logic        ready, stall;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_ctrl #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .annul_i      (annul),
      .signed_div_i (sgn),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .result_o     (result),
      .ready_o      (ready),
      .stallreq_o   (stall)
   );

   // Reference: truncating division in 64-bit arithmetic, reduced mod 2^32.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Drives one divide with start held until ready, then drops start.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] res, output int edges, output bit tmo,
                          output bit stall_ok, output logic stall_end,
                          output logic rdy_after, output logic [63:0] res_after);
      @(negedge clk);
      start = 1'b1; annul = 1'b0; op1 = a; op2 = b; sgn = s;
      #1 stall_ok = (stall === 1'b1);
      @(posedge clk);
      edges = -1;
      tmo   = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         edges++;
         if (ready === 1'b1) begin
            tmo = 1'b0;
            break;
         end
         if (stall !== 1'b1) stall_ok = 1'b0;
         op1 = $urandom; op2 = $urandom; sgn = 1'($urandom);
      end
      res       = result;
      stall_end = stall;
      start     = 1'b0;
      @(negedge clk);
      rdy_after = ready;
      res_after = result;
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; annul = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ready !== 1'b0 || result !== 64'd0 || stall !== 1'b0) begin
         n_err++;
         $display("FAIL reset: ready=%b result=%h stall=%b, want 0/0/0", ready, result, stall);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned_basic;
      logic [63:0] res, ra; int e; bit tmo, sok; logic se, rd;
      run_div(32'd100, 32'd7, 1'b0, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || e != 33) begin n_err++; $display("FAIL u100_7 latency: edges=%0d tmo=%0b, want 33", e, tmo); end
      n_cmp++;
      if (res !== 64'h00000002_0000000E) begin n_err++; $display("FAIL u100_7 result: got %h want 000000020000000e", res); end
      n_cmp++;
      if (!sok) begin n_err++; $display("FAIL u100_7 stall: stall dropped before ready, want 1"); end
      n_cmp++;
      if (se !== 1'b0) begin n_err++; $display("FAIL u100_7 stall_end: got %b want 0", se); end
      n_cmp++;
      if (rd !== 1'b0 || ra !== 64'd0) begin n_err++; $display("FAIL u100_7 release: ready=%b result=%h want 0/0", rd, ra); end
   endtask

   task automatic test_signed;
      logic [63:0] res, ra; int e; bit tmo, sok; logic se, rd;
      run_div(32'hFFFFFFF9, 32'd2, 1'b1, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || res !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL s-7_2: got %h tmo=%0b want ffffffff_fffffffd", res, tmo); end
      run_div(32'd7, 32'hFFFFFFFE, 1'b1, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || res !== 64'h00000001_FFFFFFFD) begin n_err++; $display("FAIL s7_-2: got %h tmo=%0b want 00000001_fffffffd", res, tmo); end
   endtask

   task automatic test_div_zero;
      logic [63:0] res, ra; int e; bit tmo, sok; logic se, rd;
      run_div(32'd5, 32'd0, 1'b0, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || e != 1) begin n_err++; $display("FAIL div0 latency: edges=%0d tmo=%0b want 1", e, tmo); end
      n_cmp++;
      if (res !== 64'd0 || !sok || se !== 1'b0) begin
         n_err++; $display("FAIL div0 outputs: result=%h stall_ok=%0b stall_end=%b want 0/1/0", res, sok, se);
      end
   endtask

   task automatic test_corner;
      logic [63:0] res, ra; int e; bit tmo, sok; logic se, rd;
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || res !== 64'h00000000_80000000) begin n_err++; $display("FAIL smin_-1: got %h want 00000000_80000000", res); end
      run_div(32'hFFFFFFFF, 32'd1, 1'b0, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || res !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL umax_1: got %h want 00000000_ffffffff", res); end
      run_div(32'hFFFFFFFF, 32'h80000001, 1'b0, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || res !== 64'h7FFFFFFE_00000001) begin n_err++; $display("FAIL umax_big: got %h want 7ffffffe_00000001", res); end
   endtask

   task automatic test_annul;
      logic [63:0] res, ra; int e; bit tmo, sok; logic se, rd; bit seen;
      @(negedge clk);
      start = 1'b1; annul = 1'b0; op1 = 32'd1000; op2 = 32'd3; sgn = 1'b0;
      @(posedge clk);
      repeat (11) @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      #1;
      n_cmp++;
      if (stall !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL annul_on: stall=%b ready=%b want 0/0", stall, ready); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (ready !== 1'b0) seen = 1'b1; end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL annul_noready: ready asserted=1 want 0"); end
      // start and annul together in FREE: nothing launches
      @(negedge clk);
      start = 1'b1; annul = 1'b1; op1 = 32'd8; op2 = 32'd2;
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL start_annul_stall: got %b want 0", stall); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (ready !== 1'b0 || stall !== 1'b0) seen = 1'b1; end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL start_annul_idle: activity=1 want 0"); end
      start = 1'b0; annul = 1'b0;
      run_div(32'd9, 32'd3, 1'b0, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || res !== 64'h00000000_00000003) begin n_err++; $display("FAIL after_annul: got %h want 00000000_00000003", res); end
   endtask

   task automatic test_async_reset;
      logic [63:0] res, ra; int e; bit tmo, sok; logic se, rd; bit got;
      @(negedge clk);
      start = 1'b1; annul = 1'b0; op1 = 32'd50; op2 = 32'd7; sgn = 1'b0;
      @(posedge clk);
      repeat (5) @(negedge clk);
      start = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (stall !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
         n_err++; $display("FAIL arst_on: stall=%b ready=%b result=%h want 0/0/0", stall, ready, result);
      end
      @(negedge clk); rst = 1'b1;
      run_div(32'd20, 32'd6, 1'b0, res, e, tmo, sok, se, rd, ra);
      n_cmp++;
      if (tmo || res !== 64'h00000002_00000003) begin n_err++; $display("FAIL after_arst: got %h want 00000002_00000003", res); end
      // reset while a result is being presented
      @(negedge clk);
      start = 1'b1; op1 = 32'd1000; op2 = 32'd3; sgn = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (ready === 1'b1) begin got = 1'b1; break; end
      end
      n_cmp++;
      if (!got || result !== 64'h00000001_0000014D) begin n_err++; $display("FAIL end_result: got %h ready_seen=%0b want 00000001_0000014d", result, got); end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (ready !== 1'b0 || result !== 64'd0) begin n_err++; $display("FAIL arst_end: ready=%b result=%h want 0/0", ready, result); end
      start = 1'b0;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_random;
      logic [63:0] res, ra, exp; int e; bit tmo, sok; logic se, rd;
      logic [31:0] a, b; logic s; int bad;
      logic [31:0] specials [4];
      specials[0] = 32'd0; specials[1] = 32'd1; specials[2] = 32'hFFFFFFFF; specials[3] = 32'h80000000;
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
         case ($urandom_range(0, 5))
            0:       b = specials[$urandom_range(0, 3)];
            1:       b = $urandom_range(1, 20);
            2:       b = 32'd0 - 32'($urandom_range(1, 20));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         s   = 1'($urandom);
         exp = model(a, b, s);
         run_div(a, b, s, res, e, tmo, sok, se, rd, ra);
         bad = 0;
         n_cmp++;
         if (tmo || res !== exp) begin
            n_err++; bad = 1;
            $display("FAIL rand%0d result: %h/%h s=%0b got %h want %h", i, a, b, s, res, exp);
         end
         n_cmp++;
         if (e != ((b == 32'd0) ? 1 : 33) || !sok || rd !== 1'b0 || ra !== 64'd0) begin
            n_err++;
            $display("FAIL rand%0d timing: edges=%0d stall_ok=%0b ready_after=%b result_after=%h", i, e, sok, rd, ra);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_div_zero();
      test_corner();
      test_annul();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
